cordic_vect_precond: RTL



---
 rtl/cordic_vect_precond.sv | 143 ++++++++++++++
 1 files changed

// File: rtl/cordic_vect_precond.sv
`default_nettype none
// ============================================================================
// Module   : cordic_vect_precond
// Function : Folds (x, y) into the right half-plane with a 1/2 pre-scale for
//            a vectoring CORDIC pipeline. Carries the quadrant angle offset
//            (hundredths of a degree) and a valid tag through a STAGE-deep
//            delay line, so both leave aligned with the pipeline's angle.
// Revision : 1.0 - initial release
// ============================================================================
module cordic_vect_precond #(
    parameter int N     = 16,
    parameter int STAGE = 16
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         in_valid,
    input  logic signed [N-1:0]          x_in,
    input  logic signed [N-1:0]          y_in,
    input  logic                         flush,
    output logic signed [N-1:0]          x_out,
    output logic signed [N-1:0]          y_out,
    output logic                         out_valid,
    output logic signed [N-1:0]          ang_ofs_out,
    output logic                         tag_valid,
    output logic                         pipe_busy,
    output logic [$clog2(STAGE+2)-1:0]   inflight_cnt
);

    localparam int CW = $clog2(STAGE + 2);

    localparam logic signed [N-1:0] c_ofs_pos = N'(9000);
    localparam logic signed [N-1:0] c_ofs_neg = N'(-9000);
    localparam logic [CW-1:0]       c_cnt_max = CW'(STAGE + 1);

    // Halved inputs: halving first keeps every negation in range, even -2^(N-1)
    logic signed [N-1:0] w_xh;
    logic signed [N-1:0] w_yh;
    logic                w_clr;
    logic                w_acc;

    logic signed [N-1:0] r_xo_q,  w_xo_d;
    logic signed [N-1:0] r_yo_q,  w_yo_d;
    logic                r_ov_q,  w_ov_d;
    logic signed [N-1:0] r_ofs_q, w_ofs_d;

    logic [STAGE-1:0]        r_tag_v_q, w_tag_v_d;
    logic [STAGE-1:0][N-1:0] r_tag_o_q, w_tag_o_d;

    logic [CW-1:0] r_cnt_q,  w_cnt_d;
    logic          r_busy_q, w_busy_d;

    // Pre-rotation, tag shift and in-flight bookkeeping
    always_comb begin
        w_xh      = x_in >>> 1;
        w_yh      = y_in >>> 1;
        w_clr     = rst || flush;
        w_acc     = in_valid && !w_clr;

        w_xo_d    = '0;
        w_yo_d    = '0;
        w_ov_d    = 1'b0;
        w_ofs_d   = '0;
        w_tag_v_d = '0;
        w_tag_o_d = '0;
        w_cnt_d   = r_cnt_q;
        w_busy_d  = 1'b0;

        if (w_acc) begin
            w_ov_d = 1'b1;
            if (!x_in[N-1]) begin
                w_xo_d  = w_xh;
                w_yo_d  = w_yh;
                w_ofs_d = '0;
            end else if (!y_in[N-1]) begin
                // Second quadrant (and the negative x axis): rotate by -90 deg
                w_xo_d  = w_yh;
                w_yo_d  = -w_xh;
                w_ofs_d = c_ofs_pos;
            end else begin
                // Third quadrant: rotate by +90 deg
                w_xo_d  = -w_yh;
                w_yo_d  = w_xh;
                w_ofs_d = c_ofs_neg;
            end
        end

        // Tag line is fed from the registered stage so it tracks the pipeline
        w_tag_v_d[0] = r_ov_q;
        w_tag_o_d[0] = r_ofs_q;
        for (int i = 1; i < STAGE; i++) begin
            w_tag_v_d[i] = r_tag_v_q[i-1];
            w_tag_o_d[i] = r_tag_o_q[i-1];
        end

        // Token enters on accept, leaves on the cycle its tag is presented
        if (w_acc && !r_tag_v_q[STAGE-1]) begin
            if (r_cnt_q != c_cnt_max) w_cnt_d = r_cnt_q + 1'b1;
        end else if (!w_acc && r_tag_v_q[STAGE-1]) begin
            if (r_cnt_q != '0) w_cnt_d = r_cnt_q - 1'b1;
        end

        if (w_clr) begin
            w_tag_v_d = '0;
            w_tag_o_d = '0;
            w_cnt_d   = '0;
        end

        w_busy_d = (w_cnt_d != '0);
    end

    // State registers with synchronous reset
    always_ff @(posedge clk) begin
        if (rst) begin
            r_xo_q    <= '0;
            r_yo_q    <= '0;
            r_ov_q    <= 1'b0;
            r_ofs_q   <= '0;
            r_tag_v_q <= '0;
            r_tag_o_q <= '0;
            r_cnt_q   <= '0;
            r_busy_q  <= 1'b0;
        end else begin
            r_xo_q    <= w_xo_d;
            r_yo_q    <= w_yo_d;
            r_ov_q    <= w_ov_d;
            r_ofs_q   <= w_ofs_d;
            r_tag_v_q <= w_tag_v_d;
            r_tag_o_q <= w_tag_o_d;
            r_cnt_q   <= w_cnt_d;
            r_busy_q  <= w_busy_d;
        end
    end

    assign x_out        = r_xo_q;
    assign y_out        = r_yo_q;
    assign out_valid    = r_ov_q;
    assign tag_valid    = r_tag_v_q[STAGE-1];
    assign ang_ofs_out  = r_tag_o_q[STAGE-1];
    assign inflight_cnt = r_cnt_q;
    assign pipe_busy    = r_busy_q;

endmodule
`default_nettype wire
